jtframe_vidgen: RTL

- Programmable arcade video timing generator.
- Produces the pixel/line counters plus HS, VS and blanking signals that feed jtframe_scan2x (HS, with base_pxl fetched on H/V) and the game's video pipeline.
- Runs in the 48 MHz system clock domain and advances only on pxl_cen.
- All counts are pixel-clock units; all outputs are registered.

---
 rtl/jtframe_vidgen.sv | 111 +++++++++++
 1 files changed

// File: rtl/jtframe_vidgen.sv
// Programmable arcade video timing generator: H/V pixel counters with
// zero-latency HS/VS/HB/VB decode, advancing only on pxl_cen.
module jtframe_vidgen #(
   parameter int HLEN     = 396,
   parameter int VLEN     = 262,
   parameter int HB_START = 256,
   parameter int HB_END   = 0,
   parameter int HS_START = 296,
   parameter int HS_END   = 328,
   parameter int VB_START = 240,
   parameter int VB_END   = 16,
   parameter int VS_START = 250,
   parameter int VS_END   = 253,
   parameter int CW       = 9
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pxl_cen,
   output logic [CW-1:0] H,
   output logic [CW-1:0] V,
   output logic          HS,
   output logic          VS,
   output logic          HB,
   output logic          VB,
   output logic          LHBL,
   output logic          LVBL,
   output logic          frame_start
);
   localparam logic [CW-1:0] H_LAST  = CW'(HLEN - 1);
   localparam logic [CW-1:0] V_LAST  = CW'(VLEN - 1);
   localparam logic [CW-1:0] HS_POS  = CW'(HS_START);
   localparam logic [CW-1:0] VS_ON   = CW'(VS_START);
   localparam logic [CW-1:0] VS_OFF  = CW'(VS_END);
   localparam bit            VS_USED = (VS_START != VS_END);

   // Half-open interval [s,e) that may wrap past zero; s==e is always empty.
   function automatic logic in_range(input int c, input int s, input int e);
      if (s <= e) return (s <= c) && (c < e);
      return (c >= s) || (c < e);
   endfunction

   initial begin
      if (HLEN < 2) $error("jtframe_vidgen: HLEN must be at least 2");
      if (HB_START >= HLEN || HB_END >= HLEN || HS_START >= HLEN || HS_END >= HLEN)
         $error("jtframe_vidgen: horizontal START/END must be below HLEN");
      if (VB_START >= VLEN || VB_END >= VLEN || VS_START >= VLEN || VS_END >= VLEN)
         $error("jtframe_vidgen: vertical START/END must be below VLEN");
      if ((1 << CW) < HLEN || (1 << CW) < VLEN)
         $error("jtframe_vidgen: CW too small for HLEN/VLEN");
   end

   logic [CW-1:0] h_q, h_d, v_q, v_d, h_nx, v_nx;
   logic          hs_q, hs_d, vs_q, vs_d, hb_q, hb_d, vb_q, vb_d;
   logic          frame_start_q, frame_start_d;

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no latch is inferred.
      h_nx          = (h_q == H_LAST) ? '0 : h_q + 1'b1;
      v_nx          = v_q;
      h_d           = h_q;
      v_d           = v_q;
      hs_d          = hs_q;
      vs_d          = vs_q;
      hb_d          = hb_q;
      vb_d          = vb_q;
      frame_start_d = 1'b0;
      if (h_q == H_LAST) v_nx = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      if (pxl_cen) begin
         h_d  = h_nx;
         v_d  = v_nx;
         // Decode the position being entered so outputs line up with H/V.
         hb_d = in_range(int'(h_nx), HB_START, HB_END);
         hs_d = in_range(int'(h_nx), HS_START, HS_END);
         vb_d = in_range(int'(v_nx), VB_START, VB_END);
         if (h_nx == HS_POS && v_nx == VS_ON && VS_USED) vs_d = 1'b1;
         else if (h_nx == HS_POS && v_nx == VS_OFF)      vs_d = 1'b0;
         frame_start_d = (h_nx == '0) && (v_nx == '0);
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         h_q           <= '0;
         v_q           <= '0;
         hs_q          <= in_range(0, HS_START, HS_END);
         vs_q          <= 1'b0;
         hb_q          <= in_range(0, HB_START, HB_END);
         vb_q          <= in_range(0, VB_START, VB_END);
         frame_start_q <= 1'b0;
      end else begin
         h_q           <= h_d;
         v_q           <= v_d;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         hb_q          <= hb_d;
         vb_q          <= vb_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign H           = h_q;
   assign V           = v_q;
   assign HS          = hs_q;
   assign VS          = vs_q;
   assign HB          = hb_q;
   assign VB          = vb_q;
   assign LHBL        = ~hb_q;
   assign LVBL        = ~vb_q;
   assign frame_start = frame_start_q;
endmodule
